// File: rtl/anita4_phi_coinc_trigger.sv
// rtl/anita4_phi_coinc_trigger.sv - phi-sector stretch, neighbour coincidence and holdoff-gated trigger
// Optional stretch counters built only when ANITA4_TRIG_STRETCH_EN is defined.
module anita4_phi_coinc_trigger #(
  parameter int NUM_PHI   = 16,
  parameter int NUM_POL   = 2,
  parameter int HOLDOFF_W = 8,
  parameter int CNT_W     = 8,
  parameter int STRETCH_W = 4
) (
  input  logic                       clk250_i,
  input  logic                       rst_n_i,
  input  logic [NUM_POL*NUM_PHI-1:0] phi_i,
  input  logic [NUM_POL*NUM_PHI-1:0] mask_i,
  input  logic [2*NUM_POL-1:0]       mode_i,
  input  logic [STRETCH_W-1:0]       stretch_i,
  input  logic [HOLDOFF_W-1:0]       holdoff_i,
  input  logic                       cnt_clr_i,
  output logic                       trig_o,
  output logic [NUM_POL-1:0]         pol_o,
  output logic [NUM_POL*NUM_PHI-1:0] pattern_o,
  output logic                       holdoff_o,
  output logic [CNT_W-1:0]           raw_count_o,
  output logic [CNT_W-1:0]           count_o
);

  localparam int N = NUM_POL * NUM_PHI;

  logic [N-1:0]         phi_q;
  logic [N-1:0]         str;
  logic [N-1:0]         coinc_d, coinc_q;
  logic                 any_d_q;
  logic                 trig_q;
  logic [NUM_POL-1:0]   pol_d, pol_q;
  logic [N-1:0]         pattern_q;
  logic [HOLDOFF_W-1:0] hold_d, hold_q;
  logic [CNT_W-1:0]     raw_d, raw_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;
  logic                 any, rise, issue;

  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) phi_q <= '0;
    else          phi_q <= phi_i;
  end

`ifdef ANITA4_TRIG_STRETCH_EN
  // Counter reloads from the registered hit so str spans exactly 1+stretch_i cycles.
  logic [N-1:0][STRETCH_W-1:0] str_cnt_d, str_cnt_q;

  always_comb begin
    str_cnt_d = str_cnt_q;
    str       = '0;
    for (int k = 0; k < N; k++) begin
      if (phi_q[k])                str_cnt_d[k] = stretch_i;
      else if (str_cnt_q[k] != '0) str_cnt_d[k] = str_cnt_q[k] - 1'b1;
      str[k] = phi_q[k] | (str_cnt_q[k] != '0);
    end
  end

  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) str_cnt_q <= '0;
    else          str_cnt_q <= str_cnt_d;
  end
`else
  logic unused_stretch;
  assign unused_stretch = ^stretch_i;
  assign str            = phi_q;
`endif

  always_comb begin
    coinc_d = '0;
    for (int p = 0; p < NUM_POL; p++) begin
      for (int i = 0; i < NUM_PHI; i++) begin
        case (mode_i[2*p +: 2])
          2'd0: coinc_d[p*NUM_PHI+i] = str[p*NUM_PHI+i];
          2'd1: coinc_d[p*NUM_PHI+i] = str[p*NUM_PHI+i] &
                                       (str[p*NUM_PHI+(i+NUM_PHI-1)%NUM_PHI] |
                                        str[p*NUM_PHI+(i+1)%NUM_PHI]);
          2'd2: coinc_d[p*NUM_PHI+i] = str[p*NUM_PHI+i] &
                                       str[p*NUM_PHI+(i+NUM_PHI-1)%NUM_PHI] &
                                       str[p*NUM_PHI+(i+1)%NUM_PHI];
          default: coinc_d[p*NUM_PHI+i] =
                     (str[p*NUM_PHI+(i+NUM_PHI-1)%NUM_PHI] & str[p*NUM_PHI+i]) |
                     (str[p*NUM_PHI+i] & str[p*NUM_PHI+(i+1)%NUM_PHI]) |
                     (str[p*NUM_PHI+(i+NUM_PHI-1)%NUM_PHI] & str[p*NUM_PHI+(i+1)%NUM_PHI]);
        endcase
      end
    end
    coinc_d = coinc_d & ~mask_i;
  end

  assign any   = |coinc_q;
  assign rise  = any & ~any_d_q;
  assign issue = rise & (hold_q == '0);

  always_comb begin
    pol_d = '0;
    for (int p = 0; p < NUM_POL; p++) pol_d[p] = |coinc_q[p*NUM_PHI +: NUM_PHI];
  end

  // Edges arriving during holdoff are dropped, not queued.
  always_comb begin
    hold_d = hold_q;
    if (issue)               hold_d = holdoff_i;
    else if (hold_q != '0)   hold_d = hold_q - 1'b1;
    raw_d = raw_q;
    cnt_d = cnt_q;
    if (rise)  raw_d = raw_q + 1'b1;
    if (issue) cnt_d = cnt_q + 1'b1;
    if (cnt_clr_i) begin
      raw_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      coinc_q   <= '0;
      any_d_q   <= 1'b0;
      trig_q    <= 1'b0;
      pol_q     <= '0;
      pattern_q <= '0;
      hold_q    <= '0;
      raw_q     <= '0;
      cnt_q     <= '0;
    end else begin
      coinc_q <= coinc_d;
      any_d_q <= any;
      trig_q  <= issue;
      if (issue) begin
        pol_q     <= pol_d;
        pattern_q <= coinc_q;
      end
      hold_q <= hold_d;
      raw_q  <= raw_d;
      cnt_q  <= cnt_d;
    end
  end

  assign trig_o      = trig_q;
  assign pol_o       = pol_q;
  assign pattern_o   = pattern_q;
  assign holdoff_o   = (hold_q != '0);
  assign raw_count_o = raw_q;
  assign count_o     = cnt_q;

endmodule

// File: tb/tb_anita4_phi_coinc_trigger.sv
// tb/tb_anita4_phi_coinc_trigger.sv - directed-vector bench for anita4_phi_coinc_trigger
module tb_anita4_phi_coinc_trigger;

`ifdef ANITA4_TRIG_STRETCH_EN
  localparam logic STR_EN = 1'b1;
`else
  localparam logic STR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] phi, mask;
  logic [3:0]  mode;
  logic [3:0]  stretch;
  logic [7:0]  holdoff;
  logic        cnt_clr;
  logic        trig;
  logic [1:0]  pol;
  logic [31:0] pattern;
  logic        hold;
  logic [7:0]  raw_count, count;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_cnt, exp_raw;
  logic [63:0] trig_hist, hold_hist;

  anita4_phi_coinc_trigger dut (
    .clk250_i    (clk),
    .rst_n_i     (rst_n),
    .phi_i       (phi),
    .mask_i      (mask),
    .mode_i      (mode),
    .stretch_i   (stretch),
    .holdoff_i   (holdoff),
    .cnt_clr_i   (cnt_clr),
    .trig_o      (trig),
    .pol_o       (pol),
    .pattern_o   (pattern),
    .holdoff_o   (hold),
    .raw_count_o (raw_count),
    .count_o     (count)
  );

  always #2 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Drives a one-cycle hit and returns just after the edge where the trigger can issue.
  task automatic fire(input logic [31:0] bits);
    phi = bits;
    tick();
    phi = '0;
    tick();
    tick();
  endtask

  initial begin
    rst_n = 1'b0; phi = '0; mask = '0; mode = 4'b0101; stretch = '0;
    holdoff = '0; cnt_clr = 1'b0;
    idle(3);
    check("rst_trig", trig, 0);
    check("rst_pattern", pattern, 0);
    check("rst_pol", pol, 0);
    check("rst_hold", hold, 0);
    check("rst_counts", {raw_count, count}, 0);
    rst_n = 1'b1;
    idle(2);

    // Mode 1 adjacent pair, latency check
    phi = 32'h18; tick(); phi = '0;
    tick();
    check("lat_early", trig, 0);
    tick();
    check("lat_trig", trig, 1);
    check("lat_pattern", pattern, 32'h18);
    check("lat_pol", pol, 2'b01);
    check("lat_count", count, 1);
    check("lat_raw", raw_count, 1);
    tick();
    check("lat_single", trig, 0);
    idle(3);

    // Wrap-around H0/H15, then mask H0
    fire(32'h8001_0000);
    check("wrap_pattern", pattern, 32'h8001_0000);
    check("wrap_pol", pol, 2'b10);
    idle(3);
    mask = 32'h0001_0000;
    fire(32'h8001_0000);
    check("mask_pattern", pattern, 32'h8000_0000);
    check("mask_count", {raw_count, count}, {8'd3, 8'd3});
    mask = '0;
    idle(3);
    exp_cnt = 3; exp_raw = 3;

    // Stretch 2 then 1: V5 then V6 two cycles later
    for (int r = 0; r < 2; r++) begin
      stretch = (r == 0) ? 4'd2 : 4'd1;
      phi = 32'h20; tick(); phi = '0; tick();
      phi = 32'h40; tick(); phi = '0;
      trig_hist = '0;
      for (int k = 0; k < 6; k++) begin
        tick();
        trig_hist[k] = trig;
      end
      if (r == 0 && STR_EN) begin
        exp_cnt++; exp_raw++;
        check("stretch2_hist", trig_hist, 64'h2);
      end else begin
        check("stretch_none_hist", trig_hist, 64'h0);
      end
    end
    stretch = '0;
    check("stretch_count", {raw_count, count}, {exp_raw[7:0], exp_cnt[7:0]});
    idle(4);

    // Holdoff 10: pairs at 0, 4 and 16
    holdoff = 8'd10;
    trig_hist = '0; hold_hist = '0;
    for (int c = 0; c < 32; c++) begin
      phi = (c == 0 || c == 4 || c == 16) ? 32'h18 : 32'h0;
      tick();
      trig_hist[c] = trig;
      hold_hist[c] = hold;
    end
    phi = '0;
    exp_raw += 3; exp_cnt += 2;
    check("hold_trig_hist", trig_hist, 64'h0004_0004);
    check("hold_hist", hold_hist, 64'h0FFC_0FFC);
    check("hold_counts", {raw_count, count}, {exp_raw[7:0], exp_cnt[7:0]});
    holdoff = '0;
    idle(3);

    // Modes 2 and 3
    mode = 4'b0110;
    fire(32'h180);
    check("mode2_none", trig, 0);
    check("mode2_raw", raw_count, exp_raw[7:0]);
    idle(3);
    mode = 4'b0111;
    fire(32'h180);
    check("mode3_adj_trig", trig, 1);
    check("mode3_adj_pattern", pattern, 32'h180);
    idle(3);
    fire(32'h140);
    check("mode3_lr_trig", trig, 1);
    check("mode3_lr_pattern", pattern, 32'h80);
    check("mode3_lr_pol", pol, 2'b01);
    mode = 4'b0101;
    idle(3);

    // Reset mid-holdoff with counters at 5
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    check("clr_counts", {raw_count, count}, 0);
    for (int k = 0; k < 4; k++) begin
      fire(32'h18);
      idle(2);
    end
    holdoff = 8'd10;
    fire(32'h18);
    check("pre_rst_counts", {raw_count, count}, {8'd5, 8'd5});
    check("pre_rst_hold", hold, 1);
    tick();
    rst_n = 1'b0;
    #1;
    check("async_rst_hold", hold, 0);
    check("async_rst_counts", {raw_count, count}, 0);
    check("async_rst_pattern", {pattern, pol, trig}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    fire(32'h18);
    check("post_rst_trig", trig, 1);
    check("post_rst_count", {raw_count, count}, {8'd1, 8'd1});
    holdoff = '0;
    idle(12);

    // Clear coincident with an issue
    phi = 32'h18; tick(); phi = '0; tick();
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    check("clr_issue_trig", trig, 1);
    check("clr_issue_counts", {raw_count, count}, 0);
    tick();
    check("clr_issue_after", count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/anita4_phi_coinc_trigger.md
# anita4_phi_coinc_trigger

Parametrised phi-sector coincidence trigger. It takes per-polarisation phi-sector hits and stretches each hit over a programmable window. It forms neighbour coincidences under a per-polarisation programmable mode and issues single-cycle triggers gated by a programmable holdoff. It sits between the L1 antenna-to-phi map and the TURF trigger/readout logic, and is the generalised successor to the fixed 2-polarisation adjacent-sector trigger.

## Interface
Parameters:
- NUM_PHI, 16, phi sectors per polarisation (≥3)
- NUM_POL, 2, polarisations (pol p occupies bits p*NUM_PHI +: NUM_PHI)
- HOLDOFF_W, 8, holdoff counter width
- CNT_W, 8, trigger counter width
- STRETCH_W, 4, stretch counter width

Ports:
- clk250_i  in  1  250 MHz trigger clock
- rst_n_i  in  1  asynchronous, active-low reset
- phi_i  in  NUM_POL*NUM_PHI  phi-sector hits, synchronous to clk250_i
- mask_i  in  NUM_POL*NUM_PHI  1 = sector excluded from coincidence output
- mode_i  in  2*NUM_POL  coincidence mode, 2 bits per pol
- stretch_i  in  STRETCH_W  extra cycles each hit is held
- holdoff_i  in  HOLDOFF_W  dead cycles after an issued trigger
- cnt_clr_i  in  1  synchronous clear of both counters
- trig_o  out  1  single-cycle trigger pulse
- pol_o  out  NUM_POL  pols with any coincidence at the last issue
- pattern_o  out  NUM_POL*NUM_PHI  coincidence pattern latched at the last issue
- holdoff_o  out  1  holdoff active
- raw_count_o  out  CNT_W  all coincidence rising edges
- count_o  out  CNT_W  issued triggers

## Operation
- Stretch stage (S): a per-channel down-counter is loaded with stretch_i when phi_i is high, and decrements to 0 otherwise. str = registered phi_i OR counter≠0. A hit at cycle t gives str high for cycles t+1 .. t+1+stretch_i.
- Coincidence stage (C): registered per channel. Neighbours are (i+NUM_PHI-1)%NUM_PHI and (i+1)%NUM_PHI, so sector 0 and sector NUM_PHI-1 are adjacent. Modes:
  - 0 = str[i]
  - 1 = str[i] & (left | right)
  - 2 = str[i] & left & right
  - 3 = at least 2 of {left, i, right}
  - Result is ANDed with !mask_i.
- any = OR of all coincidence bits; any_d is any delayed by one cycle. A rising edge is any & !any_d.
- Issue happens on a rising edge when the holdoff counter is 0:
  - trig_o = 1 for one cycle.
  - pattern_o ← coinc and pol_o ← per-pol OR.
  - The holdoff counter is loaded with holdoff_i and decrements to 0. holdoff_o = counter≠0.
- A rising edge during holdoff is dropped, never deferred. pattern_o and pol_o hold their last values.
- raw_count_o increments on every rising edge. count_o increments on every issue. Both wrap modulo 2^CNT_W.
- cnt_clr_i zeroes both counters. If it coincides with an increment, the clear wins.

## Timing
- Latency: phi_i at edge t gives trig_o at edge t+3 (S at t+1, C at t+2, issue at t+3). pattern_o, pol_o and the counters update at the same edge as trig_o.
- Holdoff: after an issue at edge T, no issue occurs at T+1 .. T+holdoff_i. With holdoff_i=0, the next issue needs only a new rising edge, i.e. any must fall and rise again (minimum spacing 2 cycles).
- mode_i, mask_i, stretch_i and holdoff_i are sampled live each cycle. A change mid-event takes effect on the next evaluation, without glitch protection.
- Reset (async assert, sync release): all stage registers, counters, any_d, trig_o, pol_o, pattern_o and holdoff_o go to 0. A reset mid-holdoff or mid-stretch aborts it. The first post-reset trigger needs a fresh rising edge.

## Configuration
- ANITA4_TRIG_STRETCH_EN
  - Defined: the stretch counters are built as described.
  - Undefined: stretch_i is ignored, no counters are built, and str = registered phi_i. Latency is unchanged at 3 cycles.

## Test plan
- Mode 1, stretch 0, holdoff 0: a 1-cycle pulse on phi V[3] and V[4] at t → trig_o high at t+3 only; pattern_o = bits 3 and 4; pol_o=01; count_o=1; raw_count_o=1.
- Wrap-around: a pulse on H[0] and H[15] → pattern_o bits 16 and 31 set. Mask bit 16 → only bit 31 is set.
- Stretch 2: V[5] at t and V[6] at t+2 → trig at t+5. Same stimulus with stretch 1 → no trigger. Same stimulus without ANITA4_TRIG_STRETCH_EN → no trigger.
- Holdoff 10: pulse pairs 4 cycles apart, then 12 cycles apart → the second pair is dropped; raw_count_o=3, count_o=2; holdoff_o high for exactly 10 cycles after each issue.
- Modes 2 and 3: V[7] with V[8] only → mode 2 gives no trigger. Mode 3 triggers on V[7]&V[8], and also triggers on left+right with the centre low.
- Reset asserted during holdoff with counters at 5 → all outputs 0 immediately. After release, a new pair triggers with count_o=1. cnt_clr_i coincident with an issue → count_o=0.
